// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with architectural HI/LO.
//   Starts MULT/MULTU/DIV/DIVU with a fixed latency and handles MTHI/MTLO
//   writes. MFHI/MFLO reads come out on mdu_out.
//   The result is computed at the start edge and held in phi/plo. It is
//   committed to HI/LO on the last busy edge, so the stall timing is exact
//   and no iterative divider is needed.
// Ports:
//   clk, reset (async, active-low)
//   dataA/dataB : E-stage operands (rs, rt)
//   MDUctrl     : 0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//   start       : MDUctrl qualifier for the ops that change state
//   busy        : multiply/divide in flight (registered)
//   mdu_out     : HI for MFHI, LO for MFLO, otherwise 0
//   HI, LO      : architectural registers
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [3:0]  MDUctrl,
  input  logic        start,
  output logic        busy,
  output logic [31:0] mdu_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   phi, plo;

  // Arithmetic is evaluated from the operands present at the start edge.
  logic signed [63:0] sa, sb;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur, sq, sr;
  logic [31:0] res_hi, res_lo;
  logic [CW-1:0] res_cyc;
  logic          is_op;

  assign sa     = {{32{dataA[31]}}, dataA};
  assign sb     = {{32{dataB[31]}}, dataB};
  assign prod_s = sa * sb;                        // low 64 bits are the exact signed product
  assign prod_u = {32'd0, dataA} * {32'd0, dataB};

  // Signed division goes through the magnitudes. For 0x80000000 / -1 the
  // magnitude 0x80000000 passes through unchanged, which gives LO=0x80000000
  // and HI=0 with no special case.
  assign abs_a = dataA[31] ? (32'd0 - dataA) : dataA;
  assign abs_b = dataB[31] ? (32'd0 - dataB) : dataB;
  assign uq    = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
  assign ur    = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
  assign sq    = (dataA[31] ^ dataB[31]) ? (32'd0 - uq) : uq;
  assign sr    = dataA[31] ? (32'd0 - ur) : ur;  // remainder follows the dividend's sign

  always_comb begin
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_cyc = CW'(MULT_CYCLES);
    is_op   = 1'b0;
    case (MDUctrl)
      OP_MULT:  begin is_op = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin is_op = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        is_op   = 1'b1;
        res_cyc = CW'(DIV_CYCLES);
        if (dataB == 32'd0) begin res_hi = dataA; res_lo = 32'hFFFF_FFFF; end
        else                begin res_hi = sr;    res_lo = sq;           end
      end
      OP_DIVU: begin
        is_op   = 1'b1;
        res_cyc = CW'(DIV_CYCLES);
        if (dataB == 32'd0) begin res_hi = dataA;         res_lo = 32'hFFFF_FFFF; end
        else                begin res_hi = dataA % dataB; res_lo = dataA / dataB; end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_op) begin
              phi   <= res_hi;
              plo   <= res_lo;
              cnt   <= res_cyc;
              state <= BUSY;
            end else if (MDUctrl == OP_MTHI) begin
              HI <= dataA;
            end else if (MDUctrl == OP_MTLO) begin
              LO <= dataA;
            end
          end
        end
        BUSY: begin
          // Any start arriving while busy, including on the completion edge, is dropped.
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            HI    <= phi;
            LO    <= plo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign mdu_out = (MDUctrl == OP_MFHI) ? HI :
                   (MDUctrl == OP_MFLO) ? LO : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors with hand-computed expected values for e_mdu.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB;
  logic [3:0]  MDUctrl;
  logic        start;
  logic        busy;
  logic [31:0] mdu_out, HI, LO;

  int checks = 0;
  int errors = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
    .MDUctrl(MDUctrl), .start(start), .busy(busy),
    .mdu_out(mdu_out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge of the first cycle after the start edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUctrl = op; dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUctrl = 4'd0;
  endtask

  // Counts the sampled busy cycles from now on; the bound keeps a stuck busy from hanging the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; dataA = '0; dataB = '0; MDUctrl = '0; start = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    @(negedge clk); reset = 1'b1;

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    chk("mult busy cycles", n, 32'd5);
    chk("mult HI", HI, 32'hFFFF_FFFF);
    chk("mult LO", LO, 32'hFFFF_FFFA);

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF = 0xFFFFFFFE_00000001
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu busy cycles", n, 32'd5);
    chk("multu HI", HI, 32'hFFFF_FFFE);
    chk("multu LO", LO, 32'h0000_0001);

    // DIV -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div busy cycles", n, 32'd10);
    chk("div LO", LO, 32'hFFFF_FFFD);
    chk("div HI", HI, 32'hFFFF_FFFF);

    // DIVU 0xFFFFFFF9 / 2
    issue(4'd4, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("divu busy cycles", n, 32'd10);
    chk("divu LO", LO, 32'h7FFF_FFFC);
    chk("divu HI", HI, 32'd1);

    // DIV 7 / -2: quotient -3, remainder +1
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("div pos/neg LO", LO, 32'hFFFF_FFFD);
    chk("div pos/neg HI", HI, 32'd1);

    // DIVU by zero
    issue(4'd4, 32'h1234, 32'd0);
    wait_idle(n);
    chk("divu0 busy cycles", n, 32'd10);
    chk("divu0 LO", LO, 32'hFFFF_FFFF);
    chk("divu0 HI", HI, 32'h1234);

    // DIV signed overflow
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("divovf LO", LO, 32'h8000_0000);
    chk("divovf HI", HI, 32'd0);

    // MTHI / MTLO then MFHI / MFLO
    issue(4'd7, 32'hA5A5_A5A5, 32'd0);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    issue(4'd8, 32'h5A5A_5A5A, 32'd0);
    MDUctrl = 4'd5; #1;
    chk("mfhi out", mdu_out, 32'hA5A5_A5A5);
    MDUctrl = 4'd6; #1;
    chk("mflo out", mdu_out, 32'h5A5A_5A5A);
    MDUctrl = 4'd0; #1;
    chk("none out", mdu_out, 32'd0);

    // MTHI and MULT issued while busy are dropped; old HI stays readable
    issue(4'd1, 32'd2, 32'd3);                // now in busy cycle 1
    MDUctrl = 4'd7; dataA = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);                           // busy cycle 2
    MDUctrl = 4'd1; dataA = 32'd7; dataB = 32'd7;
    @(negedge clk);                           // busy cycle 3
    start = 1'b0; MDUctrl = 4'd5; #1;
    chk("busy mfhi old", mdu_out, 32'hA5A5_A5A5);
    chk("busy HI held", HI, 32'hA5A5_A5A5);
    MDUctrl = 4'd0;
    wait_idle(n);
    chk("busy ignore cycles", n, 32'd3);
    chk("busy ignore HI", HI, 32'd0);
    chk("busy ignore LO", LO, 32'd6);
    repeat (3) @(negedge clk);
    chk("no queued op", {31'd0, busy}, 32'd0);

    // start on the completion edge is ignored
    issue(4'd1, 32'd4, 32'd4);                // busy cycle 1
    repeat (4) @(negedge clk);                // busy cycle 5, next edge completes
    MDUctrl = 4'd1; dataA = 32'd9; dataB = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUctrl = 4'd0;
    chk("completion start busy", {31'd0, busy}, 32'd0);
    chk("completion start LO", LO, 32'd16);

    // Reset mid-operation discards the op
    issue(4'd1, 32'd5, 32'd5);                // busy cycle 1
    @(negedge clk);
    @(negedge clk);                           // busy cycle 3
    reset = 1'b0; #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset HI", HI, 32'd0);
    chk("midreset LO", LO, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("postreset busy", {31'd0, busy}, 32'd0);
    chk("postreset LO", LO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
